// File: rtl/entropy_src_adaptp_ht_monitor.sv
// Adaptive proportion health test monitor: samples per-window counts and fail strobes,
// keeps watermarks, saturating fail/window counters, and a consecutive-fail alert.
module entropy_src_adaptp_ht_monitor #(
  parameter int unsigned RegWidth       = 16,
  parameter int unsigned FailCntWidth   = 8,
  parameter int unsigned ConsecCntWidth = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      active_i,
  input  logic                      clear_i,
  input  logic                      window_wrap_pulse_i,
  input  logic [RegWidth-1:0]       test_cnt_hi_i,
  input  logic [RegWidth-1:0]       test_cnt_lo_i,
  input  logic                      test_fail_hi_pulse_i,
  input  logic                      test_fail_lo_pulse_i,
  input  logic [ConsecCntWidth-1:0] alert_thresh_i,
  output logic [RegWidth-1:0]       watermark_hi_o,
  output logic [RegWidth-1:0]       watermark_lo_o,
  output logic [FailCntWidth-1:0]   total_fail_hi_o,
  output logic [FailCntWidth-1:0]   total_fail_lo_o,
  output logic [RegWidth-1:0]       window_cnt_o,
  output logic [ConsecCntWidth-1:0] consec_fail_o,
  output logic                      alert_pulse_o,
  output logic                      alert_sticky_o
);

  logic                      evt;
  logic                      fail_hi, fail_lo, fail_any;

  logic [RegWidth-1:0]       wm_hi_q, wm_hi_d;
  logic [RegWidth-1:0]       wm_lo_q, wm_lo_d;
  logic [FailCntWidth-1:0]   fail_hi_cnt_q, fail_hi_cnt_d;
  logic [FailCntWidth-1:0]   fail_lo_cnt_q, fail_lo_cnt_d;
  logic [RegWidth-1:0]       window_cnt_q, window_cnt_d;
  logic [ConsecCntWidth-1:0] consec_q, consec_d;
  logic                      alert_pulse_q, alert_pulse_d;
  logic                      alert_sticky_q, alert_sticky_d;

  // Clear has priority over an evaluation event in the same cycle.
  assign evt      = active_i && window_wrap_pulse_i && !clear_i;
  assign fail_hi  = evt && test_fail_hi_pulse_i;
  assign fail_lo  = evt && test_fail_lo_pulse_i;
  assign fail_any = fail_hi || fail_lo;

  always_comb begin
    wm_hi_d        = wm_hi_q;
    wm_lo_d        = wm_lo_q;
    fail_hi_cnt_d  = fail_hi_cnt_q;
    fail_lo_cnt_d  = fail_lo_cnt_q;
    window_cnt_d   = window_cnt_q;
    consec_d       = consec_q;
    alert_pulse_d  = 1'b0;
    alert_sticky_d = alert_sticky_q;

    if (evt) begin
      if (test_cnt_hi_i > wm_hi_q) begin
        wm_hi_d = test_cnt_hi_i;
      end
      if (test_cnt_lo_i < wm_lo_q) begin
        wm_lo_d = test_cnt_lo_i;
      end
      if (window_cnt_q != {RegWidth{1'b1}}) begin
        window_cnt_d = window_cnt_q + 1'b1;
      end
      if (fail_hi && (fail_hi_cnt_q != {FailCntWidth{1'b1}})) begin
        fail_hi_cnt_d = fail_hi_cnt_q + 1'b1;
      end
      if (fail_lo && (fail_lo_cnt_q != {FailCntWidth{1'b1}})) begin
        fail_lo_cnt_d = fail_lo_cnt_q + 1'b1;
      end
      if (fail_any) begin
        if (consec_q != {ConsecCntWidth{1'b1}}) begin
          consec_d = consec_q + 1'b1;
        end
      end else begin
        consec_d = '0;
      end
      // Edge-detect on reaching the threshold so a saturated counter does not re-pulse.
      alert_pulse_d = (alert_thresh_i != '0) && (consec_q != alert_thresh_i) &&
                      (consec_d == alert_thresh_i);
      alert_sticky_d = alert_sticky_q || alert_pulse_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wm_hi_q        <= '0;
      wm_lo_q        <= '1;
      fail_hi_cnt_q  <= '0;
      fail_lo_cnt_q  <= '0;
      window_cnt_q   <= '0;
      consec_q       <= '0;
      alert_pulse_q  <= 1'b0;
      alert_sticky_q <= 1'b0;
    end else begin
      wm_hi_q        <= wm_hi_d;
      wm_lo_q        <= wm_lo_d;
      fail_hi_cnt_q  <= fail_hi_cnt_d;
      fail_lo_cnt_q  <= fail_lo_cnt_d;
      window_cnt_q   <= window_cnt_d;
      consec_q       <= consec_d;
      alert_pulse_q  <= alert_pulse_d;
      alert_sticky_q <= alert_sticky_d;
    end
  end

  assign watermark_hi_o  = wm_hi_q;
  assign watermark_lo_o  = wm_lo_q;
  assign total_fail_hi_o = fail_hi_cnt_q;
  assign total_fail_lo_o = fail_lo_cnt_q;
  assign window_cnt_o    = window_cnt_q;
  assign consec_fail_o   = consec_q;
  assign alert_pulse_o   = alert_pulse_q;
  assign alert_sticky_o  = alert_sticky_q;

endmodule

// File: tb/tb_entropy_src_adaptp_ht_monitor.sv
// Directed plus randomized bench for the adaptive proportion monitor against an integer model.
module tb_entropy_src_adaptp_ht_monitor;

  logic        clk = 1'b0;
  logic        rst, active, clear, wrap, fhi, flo;
  logic [15:0] cnt_hi, cnt_lo;
  logic [3:0]  thresh;
  logic [15:0] wm_hi, wm_lo, win_cnt;
  logic [7:0]  tot_hi, tot_lo;
  logic [3:0]  consec;
  logic        pulse, sticky;

  int checks = 0;
  int errors = 0;

  // Reference state as plain integers.
  int m_wm_hi, m_wm_lo, m_tot_hi, m_tot_lo, m_win, m_consec, m_pulse, m_sticky;

  always #5 clk = ~clk;

  entropy_src_adaptp_ht_monitor #(
    .RegWidth      (16),
    .FailCntWidth  (8),
    .ConsecCntWidth(4)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .active_i            (active),
    .clear_i             (clear),
    .window_wrap_pulse_i (wrap),
    .test_cnt_hi_i       (cnt_hi),
    .test_cnt_lo_i       (cnt_lo),
    .test_fail_hi_pulse_i(fhi),
    .test_fail_lo_pulse_i(flo),
    .alert_thresh_i      (thresh),
    .watermark_hi_o      (wm_hi),
    .watermark_lo_o      (wm_lo),
    .total_fail_hi_o     (tot_hi),
    .total_fail_lo_o     (tot_lo),
    .window_cnt_o        (win_cnt),
    .consec_fail_o       (consec),
    .alert_pulse_o       (pulse),
    .alert_sticky_o      (sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wm_hi = 0; m_wm_lo = 65535; m_tot_hi = 0; m_tot_lo = 0;
    m_win = 0; m_consec = 0; m_pulse = 0; m_sticky = 0;
  endtask

  // Drive one cycle of inputs, advance model, then compare every output after the edge.
  task automatic step(input bit r, input bit c, input bit a, input bit w,
                      input int hi, input int lo, input bit fh, input bit fl, input int th);
    int prev;
    rst = r; clear = c; active = a; wrap = w;
    cnt_hi = hi[15:0]; cnt_lo = lo[15:0]; fhi = fh; flo = fl; thresh = th[3:0];
    if (r || c) begin
      model_reset();
    end else if (a && w) begin
      prev = m_consec;
      if (hi > m_wm_hi) m_wm_hi = hi;
      if (lo < m_wm_lo) m_wm_lo = lo;
      m_win = (m_win < 65535) ? m_win + 1 : 65535;
      if (fh) m_tot_hi = (m_tot_hi < 255) ? m_tot_hi + 1 : 255;
      if (fl) m_tot_lo = (m_tot_lo < 255) ? m_tot_lo + 1 : 255;
      m_consec = (fh || fl) ? ((m_consec < 15) ? m_consec + 1 : 15) : 0;
      m_pulse = (th != 0 && prev != th && m_consec == th) ? 1 : 0;
      if (m_pulse != 0) m_sticky = 1;
    end else begin
      m_pulse = 0;
    end
    @(posedge clk);
    #1;
    chk("watermark_hi", 32'(wm_hi), m_wm_hi);
    chk("watermark_lo", 32'(wm_lo), m_wm_lo);
    chk("total_fail_hi", 32'(tot_hi), m_tot_hi);
    chk("total_fail_lo", 32'(tot_lo), m_tot_lo);
    chk("window_cnt", 32'(win_cnt), m_win);
    chk("consec_fail", 32'(consec), m_consec);
    chk("alert_pulse", 32'(pulse), m_pulse);
    chk("alert_sticky", 32'(sticky), m_sticky);
  endtask

  // Shorthand for an evaluation event with no reset/clear.
  task automatic ev(input int hi, input int lo, input bit fh, input bit fl, input int th);
    step(0, 0, 1, 1, hi, lo, fh, fl, th);
  endtask

  initial begin
    model_reset();
    // Reset held two cycles.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Watermarks.
    ev(100, 40, 0, 0, 0);
    ev(90, 50, 0, 0, 0);
    ev(120, 30, 0, 0, 0);
    ev(120, 30, 0, 0, 0);
    chk("window_cnt_after_4", 32'(win_cnt), 4);

    // Alert at threshold 3 with four hi fails, then a pass.
    step(0, 1, 0, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++) ev(10, 10, 1, 0, 3);
    ev(10, 10, 0, 0, 3);
    chk("sticky_after_pass", 32'(sticky), 1);

    // Both fails in one event.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    ev(5, 5, 1, 1, 0);
    chk("consec_both", 32'(consec), 1);

    // Qualification: strobes without active or without wrap are ignored.
    step(0, 0, 0, 1, 999, 1, 1, 1, 2);
    step(0, 0, 1, 0, 999, 1, 1, 1, 2);
    step(0, 0, 0, 0, 999, 1, 1, 1, 2);

    // Clear coincident with an event; then threshold 0 never alerts.
    ev(7, 7, 1, 0, 2);
    step(0, 1, 1, 1, 500, 2, 1, 1, 2);
    for (int i = 0; i < 20; i++) ev(i, 100 - i, 1, i[0], 0);

    // Saturation: 260 fails with threshold 15.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) ev(i, 300 - i, 1, 0, 15);
    chk("total_fail_hi_sat", 32'(tot_hi), 255);
    chk("consec_sat", 32'(consec), 15);

    // Threshold change mid-run: no retroactive pulse when dropped below the current count.
    ev(1, 1, 1, 0, 4);
    ev(1, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) ev(1, 1, 0, 1, 4);

    // Randomized traffic with mid-run reset and clear.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
           int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/entropy_src_adaptp_ht_monitor.md
Name: entropy_src_adaptp_ht_monitor

Overview:
Consumer-side companion to the adaptive proportion health test. It samples the test's per-window count and fail-pulse outputs at each window boundary. It tracks high and low watermarks, total fail counts, windows evaluated and consecutive failing windows. It raises an alert when the consecutive-fail count reaches a programmed threshold. It sits between the adaptive proportion test and the entropy_src register/alert logic.

Parameters:
RegWidth, 16, width of count inputs, watermarks and window counter
FailCntWidth, 8, width of total fail counters
ConsecCntWidth, 4, width of consecutive-fail counter and alert threshold

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
active_i  input  1  health test enabled; when low, no evaluation events occur
clear_i  input  1  synchronous clear of all state
window_wrap_pulse_i  input  1  window-end strobe from the test
test_cnt_hi_i  input  RegWidth  hi-side window count
test_cnt_lo_i  input  RegWidth  lo-side window count
test_fail_hi_pulse_i  input  1  hi-threshold fail strobe
test_fail_lo_pulse_i  input  1  lo-threshold fail strobe
alert_thresh_i  input  ConsecCntWidth  consecutive-fail alert threshold; 0 disables the alert
watermark_hi_o  output  RegWidth  maximum test_cnt_hi_i seen
watermark_lo_o  output  RegWidth  minimum test_cnt_lo_i seen
total_fail_hi_o  output  FailCntWidth  saturating hi-fail count
total_fail_lo_o  output  FailCntWidth  saturating lo-fail count
window_cnt_o  output  RegWidth  saturating count of evaluated windows
consec_fail_o  output  ConsecCntWidth  current consecutive failing windows
alert_pulse_o  output  1  one-cycle pulse on reaching threshold
alert_sticky_o  output  1  latched alert

Behaviour:
- Evaluation event: E = active_i && window_wrap_pulse_i && !clear_i.
- Fail strobes are qualified by E. A fail strobe without E is ignored.
- All outputs are registered. Each update is visible in the cycle after E.
- Reset values (rst_i high, or clear_i high):
  - watermark_hi_o = 0
  - watermark_lo_o = all ones
  - total_fail_hi_o = total_fail_lo_o = window_cnt_o = consec_fail_o = 0
  - alert_pulse_o = alert_sticky_o = 0
- Priority: rst_i > clear_i > E.
- active_i low freezes all state; it does not clear anything.
- Watermarks, on E:
  - watermark_hi_o is updated when test_cnt_hi_i > watermark_hi_o (strictly greater).
  - watermark_lo_o is updated when test_cnt_lo_i < watermark_lo_o (strictly less).
  - Equal values cause no update.
- Window counter: on E, window_cnt_o increments by 1 and saturates at all ones with no wrap.
- Total fail counters: on E, each increments independently on its strobe and saturates at all ones. Both strobes in the same E increment both counters.
- Consecutive counter, on E:
  - fail_any = hi || lo strobe.
  - fail_any: consec_fail_o increments by 1, saturating at all ones. Simultaneous hi and lo fails still add only 1.
  - !fail_any: consec_fail_o goes to 0.
- Alert:
  - alert_pulse_o is high for one cycle after an E where alert_thresh_i != 0, the pre-update consec_fail_o != alert_thresh_i, and the post-update value == alert_thresh_i.
  - With saturation there is no re-pulse while the counter holds at the threshold.
  - alert_sticky_o is set together with alert_pulse_o. It is cleared only by rst_i or clear_i.
  - A change of alert_thresh_i mid-run takes effect at the next E. No retroactive pulse.
- Back-to-back E on consecutive cycles is supported; every event is counted.
- clear_i coincident with E: clear wins and the event is discarded.
- Reset mid-operation: all state returns to reset values in the next cycle.

Test Plan:
- Reset: assert rst_i 2 cycles -> watermark_hi=0, watermark_lo=0xFFFF, all counters 0, alert outputs 0.
- Watermarks: E with hi/lo = (100,40), then (90,50), then (120,30) -> watermark_hi 100,100,120; watermark_lo 40,40,30; window_cnt = 3.
- Alert threshold: alert_thresh=3, four consecutive E with fail_hi -> consec 1,2,3,4; alert_pulse only in the cycle after the 3rd E; sticky stays 1. A 5th E without fail -> consec=0, sticky stays 1.
- Simultaneous fails: one E with both fail_hi and fail_lo -> total_fail_hi=1, total_fail_lo=1, consec=1.
- Saturation: FailCntWidth=8, 260 failing E -> total_fail_hi=255. ConsecCntWidth=4 with thresh=15 -> consec holds at 15 and gives a single alert pulse.
- Qualification and clear: fail strobe with active_i=0 or no wrap -> no change. clear_i coincident with E -> all reset values and sticky=0. alert_thresh=0 -> never alerts.
